// File: rtl/seq_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock, LSB chunk first, result registered on completion.
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVF_EN.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             ready_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic                   accept;
  logic                   last;
  logic [CHUNK:0]         chunk_res;
  logic [WIDTH+CHUNK-1:0] acc_shift;
  logic [WIDTH-1:0]       acc_next;

  // Operands shift right each RUN cycle so the active chunk is always the low CHUNK bits.
  always_comb begin
    chunk_res = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_reg};
    acc_shift = {chunk_res[CHUNK-1:0], acc_reg};
    acc_next  = acc_shift[WIDTH+CHUNK-1:CHUNK];
  end

  // ready_reg blocks a start on the edge where reset is released.
  assign accept = start && ready_reg && (state_reg != RUN);
  assign last   = (state_reg == RUN) && (count_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        count_reg <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> CHUNK;
        b_reg     <= b_reg >> CHUNK;
        carry_reg <= chunk_res[CHUNK];
        acc_reg   <= acc_next;
        count_reg <= last ? '0 : count_reg + 1'b1;
        if (last) begin
          sum_reg  <= acc_next;
          cout_reg <= chunk_res[CHUNK];
        end
      end
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic ovf_reg;

  // Carry into the MSB is recovered from the MSB operand bits and its sum bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (last) begin
      ovf_reg <= (a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ chunk_res[CHUNK-1]) ^ chunk_res[CHUNK];
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal: 2..64).
REQ-002 SHALL provide parameter CHUNK, default 1, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  request to begin an addition.
REQ-006 SHALL provide port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL provide port b  input  WIDTH  operand B.
REQ-008 SHALL provide port cin  input  1  carry-in.
REQ-009 SHALL provide port busy  output  1  high while an addition is in progress.
REQ-010 SHALL provide port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL provide port sum  output  WIDTH  registered result.
REQ-012 SHALL provide port cout  output  1  registered carry-out of MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE).
REQ-014 start SHALL be accepted on a rising edge where start=1 and busy=0 (IDLE or DONE); a, b, cin latched on that edge; state -> RUN; chunk counter -> 0.
REQ-015 start while busy=1 SHALL be ignored; latched operands unaffected.
REQ-016 Each RUN edge SHALL add chunk[count] of A and B plus the running carry (cin for chunk 0), store the CHUNK result bits, update the running carry, increment count.
REQ-017 On the edge processing chunk NCHUNK-1, state SHALL -> DONE; sum and cout SHALL load the complete result on that same edge.
REQ-018 Latency: accepted start at edge k -> done high during the cycle following edge k+NCHUNK (WIDTH=8, CHUNK=1: 8 RUN cycles; CHUNK=8: 1 RUN cycle).
REQ-019 DONE SHALL last exactly one cycle; next edge -> RUN if start=1, else IDLE (back-to-back, no bubble).
REQ-020 sum/cout SHALL change only on the completion edge; partial results stay internal; values hold until the next completion.
REQ-021 Arithmetic: {cout, sum} = a + b + cin modulo 2^(WIDTH+1); overflow wraps (sum = 0 when a = 2^WIDTH-1, b = 1, cin = 0; cout = 1).
REQ-022 Chunk counter SHALL be ceil(log2(NCHUNK)) bits wide (min 1) and SHALL never index beyond NCHUNK-1.
REQ-023 Changes on a/b/cin during RUN SHALL NOT affect the result in flight.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, count 0, carry 0, busy 0, done 0, sum 0, cout 0 (and ovf 0 when present).
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse for it; first accepted start after release begins a fresh addition.
REQ-026 Reset release SHALL be synchronous-safe: no start accepted on the edge coincident with rst_n rising.

Configuration
REQ-027 Macro SEQ_ADDER_OVF_EN SHALL, when defined, add port ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB, registered on the completion edge, held like sum.
REQ-028 Without SEQ_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 WIDTH=8, CHUNK=1: a=8'h35, b=8'h4A, cin=0, start 1 cycle -> busy 8 cycles, done 1 cycle, sum=8'h7F, cout=0.
REQ-030 WIDTH=8, CHUNK=1: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1; with SEQ_ADDER_OVF_EN, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1.
REQ-031 start held high continuously with new operands each DONE cycle -> consecutive done pulses exactly NCHUNK+1 cycles apart, each sum correct.
REQ-032 start pulsed during RUN with different a/b -> ignored; result matches first operands; single done.
REQ-033 rst_n pulsed low at RUN cycle 4 -> busy/done/sum/cout immediately 0, no done afterwards; subsequent start yields correct result.
REQ-034 WIDTH=16, CHUNK=4 and CHUNK=16: random 1000 operand sets vs. a+b+cin model -> all match, latency 4 and 1 RUN cycles respectively.
